sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 97 +++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary pointers, registered full/empty/count flags and sticky overflow/underflow.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata is registered on each accepted read.
module sync_fifo #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_LVL  = (2**ADDRSIZE) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int              DEPTH    = 2**ADDRSIZE;
  localparam logic [ADDRSIZE:0] PTR_ONE  = 1;
  localparam logic [ADDRSIZE:0] AFULL_C  = AFULL_LVL[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AEMPTY_C = AEMPTY_LVL[ADDRSIZE:0];

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [ADDRSIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic                wfull_q, wfull_d, rempty_q, rempty_d;
  logic                overflow_q, overflow_d, underflow_q, underflow_d;
  logic                rd_acc, wr_acc;

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  always_comb begin
    rd_acc      = !rst && rinc && !rempty_q;
    wr_acc      = !rst && winc && (!wfull_q || rd_acc);
    wptr_d      = wr_acc ? wptr_q + PTR_ONE : wptr_q;
    rptr_d      = rd_acc ? rptr_q + PTR_ONE : rptr_q;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
    wfull_d     = (wptr_d[ADDRSIZE] != rptr_d[ADDRSIZE]) &&
                  (wptr_d[ADDRSIZE-1:0] == rptr_d[ADDRSIZE-1:0]);
    rempty_d    = (wptr_d == rptr_d);
    overflow_d  = overflow_q  || (winc && wfull_q && !rd_acc);
    underflow_d = underflow_q || (rinc && rempty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ADDRSIZE-1:0]] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  assign rdata = mem_q[rptr_q[ADDRSIZE-1:0]];
`else
  logic [DATASIZE-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (rst)         rdata_q <= '0;
    else if (rd_acc) rdata_q <= mem_q[rptr_q[ADDRSIZE-1:0]];
  end
  assign rdata = rdata_q;
`endif

  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

endmodule
